// File: rtl/pipeline_hazard_ctrl_pkg.sv
// rtl/pipeline_hazard_ctrl_pkg.sv - shared hazard-control state encoding and latency defaults
package pipeline_hazard_ctrl_pkg;

   typedef enum logic {
      ST_RUN      = 1'b0,
      ST_LU_STALL = 1'b1
   } hz_state_e;

   localparam int DEF_LOAD_LATENCY = 1;
   localparam int DEF_MD_LATENCY   = 4;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter, holds at all-ones
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - load-use / mult-div stall and branch flush control
module pipeline_hazard_ctrl
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int N            = 5,
   parameter int LOAD_LATENCY = DEF_LOAD_LATENCY,
   parameter int MD_LATENCY   = DEF_MD_LATENCY,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ex_mem_read,
   input  logic [N-1:0]     ex_rt,
   input  logic [N-1:0]     id_rs,
   input  logic [N-1:0]     id_rt,
   input  logic             id_uses_rt,
   input  logic             id_branch_taken,
   input  logic             id_md_start,
   input  logic             id_md_read,
   output logic             pc_enable,
   output logic             if_id_enable,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             stall,
   output logic             md_busy,
   output logic [CNT_W-1:0] stall_cycles
);

   localparam logic [3:0] LU_RELOAD = 4'(LOAD_LATENCY - 1);
   localparam logic [3:0] MD_RELOAD = 4'(MD_LATENCY);

   hz_state_e  state;
   logic [3:0] lu_cnt;
   logic [3:0] md_cnt;
   logic       lu_hit;
   logic       md_hit;

   // Register 0 is hardwired, so a load targeting it never creates a dependency.
   assign lu_hit = ex_mem_read && (ex_rt != '0)
                   && ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
   assign md_busy = (md_cnt != 4'd0);
   assign md_hit  = md_busy && (id_md_start || id_md_read);
   assign stall   = ((state == ST_RUN) && lu_hit) || (state == ST_LU_STALL) || md_hit;

   assign pc_enable    = !stall;
   assign if_id_enable = !stall;
   assign id_ex_flush  = stall;
   assign if_id_flush  = !stall && id_branch_taken;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= ST_RUN;
         lu_cnt <= 4'd0;
      end else begin
         case (state)
            ST_RUN: begin
               if (lu_hit && (LOAD_LATENCY > 1)) begin
                  state  <= ST_LU_STALL;
                  lu_cnt <= LU_RELOAD;
               end
            end
            ST_LU_STALL: begin
               if (lu_cnt == 4'd1) begin
                  state  <= ST_RUN;
                  lu_cnt <= 4'd0;
               end else begin
                  lu_cnt <= lu_cnt - 4'd1;
               end
            end
            default: begin
               state  <= ST_RUN;
               lu_cnt <= 4'd0;
            end
         endcase
      end
   end

   // A mult/div start is only taken when the ID instruction actually advances.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         md_cnt <= 4'd0;
      end else if (id_md_start && !stall && !if_id_flush) begin
         md_cnt <= MD_RELOAD;
      end else if (md_cnt != 4'd0) begin
         md_cnt <= md_cnt - 4'd1;
      end
   end

   sat_counter #(
      .WIDTH (CNT_W)
   ) u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (stall),
      .count (stall_cycles)
   );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed checks of pipeline_hazard_ctrl at two configurations
module tb_pipeline_hazard_ctrl;

   logic       clk;
   logic       reset;
   logic       ex_mem_read;
   logic [4:0] ex_rt;
   logic [4:0] id_rs;
   logic [4:0] id_rt;
   logic       id_uses_rt;
   logic       id_branch_taken;
   logic       id_md_start;
   logic       id_md_read;

   logic        a_pc_enable, a_if_id_enable, a_if_id_flush, a_id_ex_flush, a_stall, a_md_busy;
   logic [15:0] a_stall_cycles;
   logic        b_pc_enable, b_if_id_enable, b_if_id_flush, b_id_ex_flush, b_stall, b_md_busy;
   logic [3:0]  b_stall_cycles;

   int checks;
   int failures;

   pipeline_hazard_ctrl #(.N(5), .LOAD_LATENCY(1), .MD_LATENCY(4), .CNT_W(16)) dut_a (
      .clk(clk), .reset(reset), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
      .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .id_branch_taken(id_branch_taken), .id_md_start(id_md_start), .id_md_read(id_md_read),
      .pc_enable(a_pc_enable), .if_id_enable(a_if_id_enable), .if_id_flush(a_if_id_flush),
      .id_ex_flush(a_id_ex_flush), .stall(a_stall), .md_busy(a_md_busy),
      .stall_cycles(a_stall_cycles)
   );

   pipeline_hazard_ctrl #(.N(5), .LOAD_LATENCY(3), .MD_LATENCY(4), .CNT_W(4)) dut_b (
      .clk(clk), .reset(reset), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
      .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .id_branch_taken(id_branch_taken), .id_md_start(id_md_start), .id_md_read(id_md_read),
      .pc_enable(b_pc_enable), .if_id_enable(b_if_id_enable), .if_id_flush(b_if_id_flush),
      .id_ex_flush(b_id_ex_flush), .stall(b_stall), .md_busy(b_md_busy),
      .stall_cycles(b_stall_cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic idle_inputs();
      ex_mem_read = 1'b0; ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
      id_branch_taken = 1'b0; id_md_start = 1'b0; id_md_read = 1'b0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b0;
      next_cycle();
      reset = 1'b1;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b0;
      #2;
      checks += 7;
      if (a_pc_enable !== 1'b1) begin failures++; $display("FAIL reset_pc_enable got=%b exp=1", a_pc_enable); end
      if (a_if_id_enable !== 1'b1) begin failures++; $display("FAIL reset_if_id_enable got=%b exp=1", a_if_id_enable); end
      if (a_if_id_flush !== 1'b0) begin failures++; $display("FAIL reset_if_id_flush got=%b exp=0", a_if_id_flush); end
      if (a_id_ex_flush !== 1'b0) begin failures++; $display("FAIL reset_id_ex_flush got=%b exp=0", a_id_ex_flush); end
      if (a_stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", a_stall); end
      if (a_md_busy !== 1'b0) begin failures++; $display("FAIL reset_md_busy got=%b exp=0", a_md_busy); end
      if (a_stall_cycles !== 16'd0) begin failures++; $display("FAIL reset_stall_cycles got=%0d exp=0", a_stall_cycles); end
      next_cycle();
      reset = 1'b1;
   endtask

   task automatic test_load_use_1();
      do_reset();
      ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
      @(negedge clk);
      checks += 5;
      if (a_stall !== 1'b1) begin failures++; $display("FAIL lu1_stall got=%b exp=1", a_stall); end
      if (a_pc_enable !== 1'b0) begin failures++; $display("FAIL lu1_pc_enable got=%b exp=0", a_pc_enable); end
      if (a_if_id_enable !== 1'b0) begin failures++; $display("FAIL lu1_if_id_enable got=%b exp=0", a_if_id_enable); end
      if (a_id_ex_flush !== 1'b1) begin failures++; $display("FAIL lu1_id_ex_flush got=%b exp=1", a_id_ex_flush); end
      if (a_if_id_flush !== 1'b0) begin failures++; $display("FAIL lu1_if_id_flush got=%b exp=0", a_if_id_flush); end
      next_cycle();
      idle_inputs();
      @(negedge clk);
      checks += 3;
      if (a_stall !== 1'b0) begin failures++; $display("FAIL lu1_release_stall got=%b exp=0", a_stall); end
      if (a_pc_enable !== 1'b1) begin failures++; $display("FAIL lu1_release_pc_enable got=%b exp=1", a_pc_enable); end
      if (a_stall_cycles !== 16'd1) begin failures++; $display("FAIL lu1_stall_cycles got=%0d exp=1", a_stall_cycles); end
      next_cycle();
   endtask

   task automatic test_no_hazard();
      do_reset();
      ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b1;
      #1;
      checks += 2;
      if (a_stall !== 1'b0) begin failures++; $display("FAIL r0_stall_a got=%b exp=0", a_stall); end
      if (b_stall !== 1'b0) begin failures++; $display("FAIL r0_stall_b got=%b exp=0", b_stall); end
      ex_rt = 5'd9; id_rt = 5'd9; id_rs = 5'd3; id_uses_rt = 1'b0;
      #1;
      checks += 2;
      if (a_stall !== 1'b0) begin failures++; $display("FAIL rt_unused_stall_a got=%b exp=0", a_stall); end
      if (b_stall !== 1'b0) begin failures++; $display("FAIL rt_unused_stall_b got=%b exp=0", b_stall); end
      id_uses_rt = 1'b1;
      #1;
      checks += 1;
      if (a_stall !== 1'b1) begin failures++; $display("FAIL rt_used_stall got=%b exp=1", a_stall); end
      ex_mem_read = 1'b0;
      #1;
      checks += 1;
      if (a_stall !== 1'b0) begin failures++; $display("FAIL not_load_stall got=%b exp=0", a_stall); end
      next_cycle();
   endtask

   task automatic test_load_use_3_branch();
      do_reset();
      for (int c = 0; c < 4; c++) begin
         ex_mem_read = (c == 0); ex_rt = 5'd8; id_rs = 5'd8; id_branch_taken = 1'b1;
         @(negedge clk);
         checks += 3;
         if (b_stall !== (c < 3)) begin failures++; $display("FAIL lu3_stall c%0d got=%b exp=%b", c, b_stall, (c < 3)); end
         if (b_if_id_flush !== (c == 3)) begin failures++; $display("FAIL lu3_if_id_flush c%0d got=%b exp=%b", c, b_if_id_flush, (c == 3)); end
         if (a_if_id_flush !== (c != 0)) begin failures++; $display("FAIL lu1_branch_flush c%0d got=%b exp=%b", c, a_if_id_flush, (c != 0)); end
         next_cycle();
      end
      idle_inputs();
      @(negedge clk);
      checks += 1;
      if (b_stall_cycles !== 4'd3) begin failures++; $display("FAIL lu3_stall_cycles got=%0d exp=3", b_stall_cycles); end
      next_cycle();
   endtask

   task automatic test_md();
      do_reset();
      for (int c = 0; c < 6; c++) begin
         id_md_start = (c == 0); id_md_read = (c != 0);
         @(negedge clk);
         checks += 2;
         if (a_md_busy !== (c >= 1 && c <= 4)) begin failures++; $display("FAIL md_busy c%0d got=%b exp=%b", c, a_md_busy, (c >= 1 && c <= 4)); end
         if (a_stall !== (c >= 1 && c <= 4)) begin failures++; $display("FAIL md_stall c%0d got=%b exp=%b", c, a_stall, (c >= 1 && c <= 4)); end
         next_cycle();
      end
      do_reset();
      id_md_start = 1'b1; id_branch_taken = 1'b1;
      next_cycle();
      idle_inputs();
      #1;
      checks += 1;
      if (a_md_busy !== 1'b0) begin failures++; $display("FAIL md_start_flushed got=%b exp=0", a_md_busy); end
      next_cycle();
   endtask

   task automatic test_saturate();
      do_reset();
      ex_mem_read = 1'b1; ex_rt = 5'd4; id_rs = 5'd4;
      for (int c = 0; c < 19; c++) begin
         @(negedge clk);
         checks += 1;
         if (b_stall !== 1'b1) begin failures++; $display("FAIL sat_stall c%0d got=%b exp=1", c, b_stall); end
         next_cycle();
      end
      idle_inputs();
      @(negedge clk);
      checks += 2;
      if (b_stall_cycles !== 4'd15) begin failures++; $display("FAIL sat_hold got=%0d exp=15", b_stall_cycles); end
      if (a_stall_cycles !== 16'd19) begin failures++; $display("FAIL sat_wide got=%0d exp=19", a_stall_cycles); end
      next_cycle();
   endtask

   task automatic test_reset_mid();
      do_reset();
      id_md_start = 1'b1;
      next_cycle();
      id_md_start = 1'b0; ex_mem_read = 1'b1; ex_rt = 5'd7; id_rs = 5'd7;
      next_cycle();
      idle_inputs();
      @(negedge clk);
      checks += 2;
      if (b_stall !== 1'b1) begin failures++; $display("FAIL mid_pre_stall got=%b exp=1", b_stall); end
      if (b_md_busy !== 1'b1) begin failures++; $display("FAIL mid_pre_md_busy got=%b exp=1", b_md_busy); end
      #1;
      reset = 1'b0;
      #1;
      checks += 3;
      if (b_stall !== 1'b0) begin failures++; $display("FAIL mid_reset_stall got=%b exp=0", b_stall); end
      if (b_md_busy !== 1'b0) begin failures++; $display("FAIL mid_reset_md_busy got=%b exp=0", b_md_busy); end
      if (b_stall_cycles !== 4'd0) begin failures++; $display("FAIL mid_reset_stall_cycles got=%0d exp=0", b_stall_cycles); end
      next_cycle();
      reset = 1'b1;
   endtask

   initial begin
      checks = 0;
      failures = 0;
      reset = 1'b0;
      idle_inputs();
      #1;
      test_reset();
      test_load_use_1();
      test_no_hazard();
      test_load_use_3_branch();
      test_md();
      test_saturate();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
